// File: rtl/dftprobe_pkg.sv
// dftprobe_pkg: shared constants for the multi-channel DFT probe bank.
//   - Scan-chain layout: each channel owns BITS_PER_CH consecutive chain bits,
//     with the value bit at VAL_OFS and the aux (enable/edge) bit at AUX_OFS.
//   - Legal ranges for the channel count and the synchroniser depth.
//   - clamp_stages() forces a requested synchroniser depth into the legal range.
package dftprobe_pkg;

    localparam int unsigned VAL_OFS         = 0;
    localparam int unsigned AUX_OFS         = 1;
    localparam int unsigned BITS_PER_CH     = 2;
    localparam int unsigned MAX_NCH         = 32;
    localparam int unsigned MIN_SYNC_STAGES = 2;
    localparam int unsigned MAX_SYNC_STAGES = 4;

    function automatic int unsigned clamp_stages(int unsigned s);
        if (s < MIN_SYNC_STAGES) return MIN_SYNC_STAGES;
        if (s > MAX_SYNC_STAGES) return MAX_SYNC_STAGES;
        return s;
    endfunction

endpackage

// File: rtl/dftprobe_sync.sv
// dftprobe_sync: one-channel input synchroniser with a sticky edge flag.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   d_i         - asynchronous functional net
//   settled_i   - edge detection enable (high once the settle counter saturates)
//   clr_i       - clear the sticky edge flag (a capture strobe)
//   q_o         - synchronised value (SYNC_STAGES cycles of latency)
//   edge_o      - sticky edge flag
module dftprobe_sync
    import dftprobe_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    input  logic settled_i,
    input  logic clr_i,
    output logic q_o,
    output logic edge_o
);

    localparam int unsigned STAGES = clamp_stages(SYNC_STAGES);

    logic [STAGES-1:0] chain_q;
    logic              edge_q;
    logic              change;

    // The flag is raised on the same edge that the new value reaches q_o, so the
    // comparison is between the last stage and the stage feeding it.
    assign change = chain_q[STAGES-1] ^ chain_q[STAGES-2];

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
            edge_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
            // A new edge wins over a coincident clear so the event is not lost.
            edge_q  <= (edge_q & ~clr_i) | (settled_i & change);
        end
    end

    assign q_o    = chain_q[STAGES-1];
    assign edge_o = edge_q;

endmodule

// File: rtl/dftprobe_bank.sv
// dftprobe_bank: NCH-channel probe that passes through, observes or forces
// internal nets under control of a serial scan chain.
// Ports:
//   clk, rst                - scan clock, synchronous active-high reset
//   i [NCH]                 - functional nets (asynchronous to clk)
//   o [NCH]                 - probed nets to consumers (combinational mux)
//   ten                     - global test enable
//   tdi / tdo               - serial scan in / registered scan out
//   shift, capture, update  - chain strobes (capture > shift; update is independent)
//   CELG, CELSUB, CELV      - supply pins, no logic function
module dftprobe_bank
    import dftprobe_pkg::*;
#(
    parameter int unsigned NCH         = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] i,
    output logic [NCH-1:0] o,
    input  logic           ten,
    input  logic           tdi,
    output logic           tdo,
    input  logic           shift,
    input  logic           capture,
    input  logic           update,
    input  logic           CELG,
    input  logic           CELSUB,
    input  logic           CELV
);

    localparam int unsigned SW     = BITS_PER_CH * NCH;
    localparam int unsigned STAGES = clamp_stages(SYNC_STAGES);
    localparam int unsigned CW     = $clog2(STAGES + 1);

    logic [CW-1:0]  settle_q;
    logic           settled;
    logic [SW-1:0]  sr_q;
    logic [SW-1:0]  cap_image;
    logic [NCH-1:0] sr_val;
    logic [NCH-1:0] sr_aux;
    logic [NCH-1:0] ur_en_q;
    logic [NCH-1:0] ur_val_q;
    logic [NCH-1:0] sync_i;
    logic [NCH-1:0] edge_flag;
    logic           tdo_q;
    logic           unused_supply;

    assign unused_supply = CELG ^ CELSUB ^ CELV;

    // Edge detection stays off until every synchroniser has flushed its reset value.
    assign settled = (settle_q == CW'(STAGES));

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        dftprobe_sync #(
            .SYNC_STAGES (STAGES)
        ) u_sync (
            .clk       (clk),
            .rst       (rst),
            .d_i       (i[n]),
            .settled_i (settled),
            .clr_i     (ten & capture),
            .q_o       (sync_i[n]),
            .edge_o    (edge_flag[n])
        );
    end

    always_comb begin
        cap_image = '0;
        sr_val    = '0;
        sr_aux    = '0;
        for (int n = 0; n < NCH; n++) begin
            cap_image[BITS_PER_CH*n + VAL_OFS] = sync_i[n];
            cap_image[BITS_PER_CH*n + AUX_OFS] = edge_flag[n];
            sr_val[n] = sr_q[BITS_PER_CH*n + VAL_OFS];
            sr_aux[n] = sr_q[BITS_PER_CH*n + AUX_OFS];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            settle_q <= '0;
            sr_q     <= '0;
            ur_en_q  <= '0;
            ur_val_q <= '0;
            tdo_q    <= 1'b0;
        end else begin
            if (!settled) settle_q <= settle_q + 1'b1;
            if (ten) begin
                if (capture) begin
                    sr_q <= cap_image;
                end else if (shift) begin
                    sr_q  <= {tdi, sr_q[SW-1:1]};
                    tdo_q <= sr_q[0];
                end
                // Reads pre-edge SR, so all channels switch atomically.
                if (update) begin
                    ur_en_q  <= sr_aux;
                    ur_val_q <= sr_val;
                end
            end else begin
                // Drop stale forces so they cannot reappear when ten returns.
                ur_en_q <= '0;
            end
        end
    end

    assign tdo = tdo_q;
    // Gating with ten releases forces immediately, ahead of the clearing edge.
    assign o   = ((ur_en_q & {NCH{ten}}) & ur_val_q) | (~(ur_en_q & {NCH{ten}}) & i);

endmodule

// File: tb/tb_dftprobe_bank.sv
module tb_dftprobe_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] i = 4'b0000;
    logic [3:0] o;
    logic       ten = 1'b0;
    logic       tdi = 1'b0;
    logic       tdo;
    logic       shift = 1'b0;
    logic       capture = 1'b0;
    logic       update = 1'b0;
    logic       celg = 1'b0;
    logic       celsub = 1'b0;
    logic       celv = 1'b1;

    int n_checks = 0;
    int n_fail = 0;

    logic [3:0] exp_o[$];
    logic       exp_tdo[$];
    logic [7:0] exp_scan[$];

    logic [3:0] e4;
    logic       e1;
    logic [7:0] e8;
    logic [7:0] obs;

    always #5 clk = ~clk;

    dftprobe_bank #(
        .NCH         (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i       (i),
        .o       (o),
        .ten     (ten),
        .tdi     (tdi),
        .tdo     (tdo),
        .shift   (shift),
        .capture (capture),
        .update  (update),
        .CELG    (celg),
        .CELSUB  (celsub),
        .CELV    (celv)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic scan_in(input logic [7:0] v);
        for (int k = 0; k < 8; k++) begin
            tdi   = v[k];
            shift = 1'b1;
            cyc(1);
        end
        shift = 1'b0;
        tdi   = 1'b0;
    endtask

    task automatic scan_out(output logic [7:0] bits);
        for (int k = 0; k < 8; k++) begin
            tdi   = 1'b0;
            shift = 1'b1;
            cyc(1);
            bits[k] = tdo;
        end
        shift = 1'b0;
    endtask

    task automatic pulse_capture();
        capture = 1'b1;
        cyc(1);
        capture = 1'b0;
    endtask

    task automatic pulse_update();
        update = 1'b1;
        cyc(1);
        update = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ten = 1'b0; i = 4'b1010;
        exp_o.push_back(4'b1010);
        exp_tdo.push_back(1'b0);
        cyc(1);
        rst = 1'b0;
        #1;
        n_checks++; e4 = exp_o.pop_front();
        if (o !== e4) begin n_fail++; $display("FAIL reset_o: o=%b expected %b", o, e4); end
        n_checks++; e1 = exp_tdo.pop_front();
        if (tdo !== e1) begin n_fail++; $display("FAIL reset_tdo: tdo=%b expected %b", tdo, e1); end
        // Settling must not produce edge flags on the 0->1 channels.
        cyc(3);
        ten = 1'b1;
        exp_scan.push_back(8'b0100_0100);
        pulse_capture();
        scan_out(obs);
        n_checks++; e8 = exp_scan.pop_front();
        if (obs !== e8) begin n_fail++; $display("FAIL reset_no_edges: scan=%b expected %b", obs, e8); end
        // Strobes with ten=0 are ignored.
        scan_in(8'b0000_0011);
        ten = 1'b0; tdi = 1'b1; shift = 1'b1;
        exp_tdo.push_back(1'b0);
        cyc(1);
        shift = 1'b0; tdi = 1'b0;
        n_checks++; e1 = exp_tdo.pop_front();
        if (tdo !== e1) begin n_fail++; $display("FAIL ten0_shift: tdo=%b expected %b", tdo, e1); end
        pulse_update();
        ten = 1'b1; i = 4'b0000;
        exp_o.push_back(4'b0000);
        #1;
        n_checks++; e4 = exp_o.pop_front();
        if (o !== e4) begin n_fail++; $display("FAIL ten0_update: o=%b expected %b", o, e4); end
        // SR held through ten=0, so a real update now forces ch0 high.
        exp_o.push_back(4'b0001);
        pulse_update();
        n_checks++; e4 = exp_o.pop_front();
        if (o !== e4) begin n_fail++; $display("FAIL ten0_sr_hold: o=%b expected %b", o, e4); end
        ten = 1'b0; i = 4'b0101;
        exp_o.push_back(4'b0101);
        #1;
        n_checks++; e4 = exp_o.pop_front();
        if (o !== e4) begin n_fail++; $display("FAIL passthrough: o=%b expected %b", o, e4); end
        cyc(1);
    endtask

    task automatic test_force();
        ten = 1'b1;
        scan_in(8'b1000_0011);
        i = 4'b1111;
        exp_o.push_back(4'b1111);
        #1;
        n_checks++; e4 = exp_o.pop_front();
        if (o !== e4) begin n_fail++; $display("FAIL force_pre_update: o=%b expected %b", o, e4); end
        exp_o.push_back(4'b0111);
        pulse_update();
        n_checks++; e4 = exp_o.pop_front();
        if (o !== e4) begin n_fail++; $display("FAIL force_apply: o=%b expected %b", o, e4); end
        i = 4'b0000;
        exp_o.push_back(4'b0001);
        #1;
        n_checks++; e4 = exp_o.pop_front();
        if (o !== e4) begin n_fail++; $display("FAIL force_hold: o=%b expected %b", o, e4); end
        ten = 1'b0;
        exp_o.push_back(4'b0000);
        #1;
        n_checks++; e4 = exp_o.pop_front();
        if (o !== e4) begin n_fail++; $display("FAIL force_release: o=%b expected %b", o, e4); end
        cyc(1);
        ten = 1'b1;
        exp_o.push_back(4'b0000);
        #1;
        n_checks++; e4 = exp_o.pop_front();
        if (o !== e4) begin n_fail++; $display("FAIL force_cleared: o=%b expected %b", o, e4); end
    endtask

    task automatic test_observe();
        ten = 1'b1; i = 4'b0001;
        cyc(4);
        pulse_capture();
        i = 4'b0101;
        cyc(3);
        exp_scan.push_back(8'b0011_0001);
        pulse_capture();
        scan_out(obs);
        n_checks++; e8 = exp_scan.pop_front();
        if (obs !== e8) begin n_fail++; $display("FAIL observe: scan=%b expected %b", obs, e8); end
    endtask

    task automatic test_edge_capture();
        pulse_capture();
        i = 4'b0111;
        cyc(1);
        // Synced edge on ch1 arrives on this capture edge.
        exp_scan.push_back(8'b0001_0001);
        pulse_capture();
        scan_out(obs);
        n_checks++; e8 = exp_scan.pop_front();
        if (obs !== e8) begin n_fail++; $display("FAIL edge_in_capture: scan=%b expected %b", obs, e8); end
        exp_scan.push_back(8'b0001_1101);
        pulse_capture();
        scan_out(obs);
        n_checks++; e8 = exp_scan.pop_front();
        if (obs !== e8) begin n_fail++; $display("FAIL edge_kept: scan=%b expected %b", obs, e8); end
    endtask

    task automatic test_back_to_back();
        scan_in(8'hA5);
        exp_scan.push_back(8'b0001_0101);
        capture = 1'b1; shift = 1'b1; tdi = 1'b1;
        cyc(1);
        capture = 1'b0; shift = 1'b0; tdi = 1'b0;
        scan_out(obs);
        n_checks++; e8 = exp_scan.pop_front();
        if (obs !== e8) begin n_fail++; $display("FAIL capture_shift: scan=%b expected %b", obs, e8); end
        scan_in(8'b0000_0011);
        i = 4'b0000;
        exp_o.push_back(4'b0001);
        exp_tdo.push_back(1'b1);
        update = 1'b1; shift = 1'b1; tdi = 1'b1;
        cyc(1);
        update = 1'b0; shift = 1'b0; tdi = 1'b0;
        n_checks++; e4 = exp_o.pop_front();
        if (o !== e4) begin n_fail++; $display("FAIL update_shift_o: o=%b expected %b", o, e4); end
        n_checks++; e1 = exp_tdo.pop_front();
        if (tdo !== e1) begin n_fail++; $display("FAIL update_shift_tdo: tdo=%b expected %b", tdo, e1); end
        ten = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset_mid_force();
        ten = 1'b1; i = 4'b1111;
        scan_in(8'b0000_0010);
        exp_o.push_back(4'b1110);
        pulse_update();
        n_checks++; e4 = exp_o.pop_front();
        if (o !== e4) begin n_fail++; $display("FAIL mid_force_apply: o=%b expected %b", o, e4); end
        exp_o.push_back(4'b1111);
        exp_tdo.push_back(1'b0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        n_checks++; e4 = exp_o.pop_front();
        if (o !== e4) begin n_fail++; $display("FAIL mid_reset_o: o=%b expected %b", o, e4); end
        n_checks++; e1 = exp_tdo.pop_front();
        if (tdo !== e1) begin n_fail++; $display("FAIL mid_reset_tdo: tdo=%b expected %b", tdo, e1); end
        exp_scan.push_back(8'h00);
        scan_out(obs);
        n_checks++; e8 = exp_scan.pop_front();
        if (obs !== e8) begin n_fail++; $display("FAIL mid_reset_sr: scan=%b expected %b", obs, e8); end
        exp_scan.push_back(8'b0101_0101);
        pulse_capture();
        scan_out(obs);
        n_checks++; e8 = exp_scan.pop_front();
        if (obs !== e8) begin n_fail++; $display("FAIL mid_reset_no_edges: scan=%b expected %b", obs, e8); end
    endtask

    initial begin
        test_reset();
        test_force();
        test_observe();
        test_edge_capture();
        test_back_to_back();
        test_reset_mid_force();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
